// File: rtl/rr_enc_arb4.sv
// Four-way round-robin arbiter with encoded grant index, bounded hold time
// and a running count of grants issued.
//
// One owner at a time: a grant is issued from IDLE one cycle after a request
// is seen, held until the owner signals done, drops its request, or exceeds
// TIMEOUT cycles, and is always followed by at least one IDLE cycle.
module rr_enc_arb4 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout_err,
  output logic [7:0] gnt_count
);

  localparam logic StIdle  = 1'b0;
  localparam logic StGrant = 1'b1;

  logic       state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       tmo_q, tmo_d;
  logic [7:0] cnt_q, cnt_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic       owner_req;
  logic       hit_limit;
  logic       release_now;

  // Rotating priority search starting just after the last winner.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req   = req[idx_q];
  assign hit_limit   = (hold_q == 8'(TIMEOUT));
  assign release_now = done || !owner_req || hit_limit;

  // Next-state logic for the IDLE/GRANT controller and all registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          ptr_d   = win_idx;
          hold_d  = 8'd1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      StGrant: begin
        if (release_now) begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          idx_d   = 2'b00;
          valid_d = 1'b0;
          hold_d  = 8'd0;
          // Flag only a forced release: a voluntary done or req drop wins.
          tmo_d   = hit_limit && !done && owner_req;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; ptr=3 gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd3;
      hold_q  <= 8'd0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'b00;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = idx_q;
  assign gnt_valid   = valid_q;
  assign timeout_err = tmo_q;
  assign gnt_count   = cnt_q;

endmodule
